// File: rtl/tremolo_gain_apply.sv
// tremolo_gain_apply: slew-limits the tremolo gain per accepted sample and
// applies it to a signed audio stream through a fixed 3-stage multiply/round pipe.
module tremolo_gain_apply #(
  parameter int              DWIDTH   = 16,
  parameter int              GWIDTH   = 17,
  parameter int              FRAC     = 16,
  parameter logic [GWIDTH-1:0] MAX_STEP = 'h100
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [GWIDTH-1:0] gain_i,
  input  logic              enable_i,
  input  logic [DWIDTH-1:0] sample_i,
  input  logic              sample_valid_i,
  output logic [DWIDTH-1:0] sample_o,
  output logic              sample_valid_o,
  output logic [GWIDTH-1:0] gain_o
);

  localparam int PW = DWIDTH + GWIDTH + 1;
  localparam logic [GWIDTH-1:0]    UNITY = GWIDTH'(1) << FRAC;
  localparam logic signed [PW-1:0] HALF  = PW'(1) << (FRAC - 1);
  localparam logic signed [PW-1:0] SMAX  = PW'((1 << (DWIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] SMIN  = -SMAX - PW'(1);

  // vld_pipe_q[0]: stage 0 (sample + gain), [1]: product, [2]: output
  logic [2:0]               vld_pipe_q;
  logic [GWIDTH-1:0]        gain_q, gain_d;
  logic [GWIDTH-1:0]        g0_q;
  logic [DWIDTH-1:0]        s0_q;
  logic signed [PW-1:0]     prod_q, prod_d;
  logic [DWIDTH-1:0]        sample_q, sat_d;

  logic [GWIDTH-1:0]        target;
  logic [GWIDTH:0]          tgt_x, g_x, st_x;
  logic signed [PW-1:0]     rnd, shf;

  // Slew limiter: move gain_q toward the clamped target by at most MAX_STEP
  // per accepted sample; compared one bit wider so the sums never wrap.
  always_comb begin
    target = UNITY;
    if (enable_i && (gain_i < UNITY)) target = gain_i;
    tgt_x  = {1'b0, target};
    g_x    = {1'b0, gain_q};
    st_x   = {1'b0, MAX_STEP};
    gain_d = gain_q;
    if (sample_valid_i) begin
      if (tgt_x > g_x + st_x)      gain_d = gain_q + MAX_STEP;
      else if (tgt_x + st_x < g_x) gain_d = gain_q - MAX_STEP;
      else                         gain_d = target;
    end
  end

  // Multiply the stage-0 sample by the gain captured with that same sample,
  // so back-to-back gain changes never skew onto a neighbouring sample.
  always_comb begin
    prod_d = $signed({{(GWIDTH+1){s0_q[DWIDTH-1]}}, s0_q}) *
             $signed({{(DWIDTH+1){1'b0}}, g0_q});
  end

  // Round half-up, floor shift, then saturate to the sample range.
  always_comb begin
    rnd   = prod_q + HALF;
    shf   = rnd >>> FRAC;
    sat_d = shf[DWIDTH-1:0];
    if (shf > SMAX)      sat_d = SMAX[DWIDTH-1:0];
    else if (shf < SMIN) sat_d = SMIN[DWIDTH-1:0];
  end

  // Pipeline registers; data stages load only when their valid bit moves in,
  // so sample_o holds between strobes.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      vld_pipe_q <= '0;
      gain_q     <= UNITY;
      g0_q       <= UNITY;
      s0_q       <= '0;
      prod_q     <= '0;
      sample_q   <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[1:0], sample_valid_i};
      gain_q     <= gain_d;
      if (sample_valid_i) begin
        s0_q <= sample_i;
        g0_q <= gain_d;
      end
      if (vld_pipe_q[0]) prod_q   <= prod_d;
      if (vld_pipe_q[1]) sample_q <= sat_d;
    end
  end

  assign sample_o       = sample_q;
  assign sample_valid_o = vld_pipe_q[2];
  assign gain_o         = gain_q;

endmodule

// File: tb/tb_tremolo_gain_apply.sv
// Directed bench for tremolo_gain_apply with hand-computed expectations.
module tb_tremolo_gain_apply;

  logic        clk = 1'b0;
  logic        srst;
  logic [16:0] gain;
  logic        en;
  logic [15:0] sample;
  logic        valid;
  logic [15:0] so;
  logic        vo;
  logic [16:0] go;

  int nvec = 0;
  int nerr = 0;

  tremolo_gain_apply dut (
    .clk_i          (clk),
    .srst_i         (srst),
    .gain_i         (gain),
    .enable_i       (en),
    .sample_i       (sample),
    .sample_valid_i (valid),
    .sample_o       (so),
    .sample_valid_o (vo),
    .gain_o         (go)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    srst = 1'b1; valid = 1'b0;
    tick();
    srst = 1'b0;
  endtask

  // one isolated sample; after return the output strobe is visible
  task automatic send1(input logic [15:0] s);
    sample = s; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int n, m, exp_so;
    logic exp_v;
    srst = 1'b0; valid = 1'b0; sample = '0; gain = '0; en = 1'b0;
    tick();

    // reset overrides simultaneous valid
    srst = 1'b1; valid = 1'b1; sample = 16'd1000; en = 1'b1; gain = 17'h08000;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_vld", int'(vo), 0);
      chk("rst_so", int'($signed(so)), 0);
      chk("rst_gain", int'(go), 'h10000);
    end
    srst = 1'b0; valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_vld", int'(vo), 0);
      chk("post_rst_so", int'($signed(so)), 0);
      chk("post_rst_gain", int'(go), 'h10000);
    end

    // slew down to half gain, one step per sample
    en = 1'b1; gain = 17'h08000; sample = 16'd16384; valid = 1'b1;
    for (int k = 1; k <= 128; k++) begin
      tick();
      chk("slew_dn_gain", int'(go), 'h10000 - k * 'h100);
    end
    repeat (3) tick();
    chk("slew_dn_vld", int'(vo), 1);
    chk("slew_dn_so", int'($signed(so)), 8192);
    valid = 1'b0;
    tick(); tick();

    // rounding at settled 0x08000
    send1(16'd1);      chk("rnd_p1_vld", int'(vo), 1); chk("rnd_p1", int'($signed(so)), 1);
    send1(16'hFFFF);   chk("rnd_m1", int'($signed(so)), 0);
    send1(16'h7FFF);   chk("rnd_max", int'($signed(so)), 16384);
    send1(16'h8000);   chk("rnd_min", int'($signed(so)), -16384);
    chk("rnd_gain", int'(go), 'h08000);

    // disable: ramp back to unity
    en = 1'b0; sample = 16'd16384; valid = 1'b1;
    for (int k = 1; k <= 128; k++) begin
      tick();
      chk("slew_up_gain", int'(go), 'h08000 + k * 'h100);
    end
    repeat (3) tick();
    chk("slew_up_so", int'($signed(so)), 16384);
    valid = 1'b0;
    tick();

    // clamp above unity
    do_reset();
    en = 1'b1; gain = 17'h1FFFF;
    send1(16'h8000);
    chk("clamp_gain", int'(go), 'h10000);
    chk("clamp_min", int'($signed(so)), -32768);
    send1(16'h7FFF);
    chk("clamp_max", int'($signed(so)), 32767);
    chk("clamp_gain2", int'(go), 'h10000);

    // latency, ordering, hold; pulses at relative cycles 0,1,2,10
    do_reset();
    en = 1'b1; gain = 17'h08000; sample = 16'd256;
    n = 0; m = 0; exp_so = 0;
    for (int c = 0; c < 16; c++) begin
      valid = (c == 0 || c == 1 || c == 2 || c == 10);
      tick();
      if (valid) n++;
      exp_v = ((c + 1 - 3) == 0 || (c + 1 - 3) == 1 || (c + 1 - 3) == 2 || (c + 1 - 3) == 10);
      if (exp_v) begin
        exp_so = 255 - m;  // 256 * (0x10000 - (m+1)*0x100) / 0x10000
        m++;
      end
      chk("lat_vld", int'(vo), int'(exp_v));
      chk("lat_so", int'($signed(so)), exp_so);
      chk("lat_gain", int'(go), 'h10000 - n * 'h100);
    end
    valid = 1'b0;

    // reset in the middle of a burst discards in-flight samples
    do_reset();
    en = 1'b1; gain = 17'h08000; sample = 16'd500; valid = 1'b1;
    tick();
    tick();
    chk("mid_gain_pre", int'(go), 'h0FE00);
    srst = 1'b1;
    tick();
    srst = 1'b0; valid = 1'b0;
    chk("mid_vld0", int'(vo), 0);
    chk("mid_gain0", int'(go), 'h10000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_vld", int'(vo), 0);
      chk("mid_so", int'($signed(so)), 0);
      chk("mid_gain", int'(go), 'h10000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
